// File: rtl/fifo_pkg.sv
// Shared constants, typedefs and threshold helpers for the synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_DEPTH  = 1024;
  localparam int unsigned DEF_UPP_TH = 4;
  localparam int unsigned DEF_LOW_TH = 2;

  localparam int unsigned DEF_PTR_W  = $clog2(DEF_DEPTH);
  localparam int unsigned DEF_CNT_W  = DEF_PTR_W + 1;

  typedef logic [DEF_PTR_W-1:0] ptr_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Level at or above which the FIFO reports almost-full (saturates at 0).
  function automatic int unsigned alm_full_th(input int unsigned depth,
                                              input int unsigned upp_th);
    return (upp_th >= depth) ? 0 : depth - upp_th;
  endfunction

  // Level at or below which the FIFO reports almost-empty (capped at depth).
  function automatic int unsigned alm_empty_th(input int unsigned depth,
                                               input int unsigned low_th);
    return (low_th > depth) ? depth : low_th;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with a registered, resettable read port.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_W = DEF_DATA_W,
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is never cleared; reset only makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address, so a full-FIFO read+write is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock circular-buffer FIFO with registered data and status flags.
// Optional sticky overflow/underflow outputs are enabled by FIFO_ERR_FLAGS_EN.
module sync_fifo_core
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned UPP_TH = DEF_UPP_TH,
  parameter int unsigned LOW_TH = DEF_LOW_TH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic              o_alm_empty,
  output logic              o_overflow,
  output logic              o_underflow
`else
  output logic              o_alm_empty
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(alm_full_th(DEPTH, UPP_TH));
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(alm_empty_th(DEPTH, LOW_TH));

  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_core: DEPTH must be a power of two and at least 4");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wr_acc;
  logic             rd_acc;

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  always_comb begin
    rd_acc  = i_rden & ~o_empty;
    wr_acc  = i_wren & (~o_full | rd_acc);
    cnt_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= cnt_nxt;
    end
  end

  // Flags are computed from the next count so they line up with count itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_full  <= 1'b0;
      o_alm_empty <= 1'b1;
    end else begin
      o_full      <= (cnt_nxt == FULL_LVL);
      o_empty     <= (cnt_nxt == '0);
      o_alm_full  <= (cnt_nxt >= AF_LVL);
      o_alm_empty <= (cnt_nxt <= AE_LVL);
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky until reset: record any dropped write or ignored read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wren & ~wr_acc) o_overflow  <= 1'b1;
      if (i_rden & ~rd_acc) o_underflow <= 1'b1;
    end
  end
`endif

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (i_wrdata),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (o_rddata)
  );

endmodule

// File: tb/tb_sync_fifo_core.sv
// Randomised bench for sync_fifo_core against a queue-based reference model.
module tb_sync_fifo_core;
  import fifo_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned DP = DEF_DEPTH;
  localparam int unsigned UT = DEF_UPP_TH;
  localparam int unsigned LT = DEF_LOW_TH;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wren;
  logic [DW-1:0] i_wrdata;
  logic          i_rden;
  logic [DW-1:0] o_rddata;
  logic          o_full, o_empty, o_alm_full, o_alm_empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic          o_overflow, o_underflow;
`endif

  sync_fifo_core #(
    .DATA_W (DW),
    .DEPTH  (DP),
    .UPP_TH (UT),
    .LOW_TH (LT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wren      (i_wren),
    .i_wrdata    (i_wrdata),
    .i_rden      (i_rden),
    .o_rddata    (o_rddata),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_alm_full  (o_alm_full),
`ifdef FIFO_ERR_FLAGS_EN
    .o_alm_empty (o_alm_empty),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`else
    .o_alm_empty (o_alm_empty)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, plus last read word and sticky errors.
  logic [DW-1:0] q [$];
  logic [DW-1:0] exp_rd;
  bit            exp_ovf;
  bit            exp_unf;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("rddata",    o_rddata,         exp_rd);
    chk("full",      DW'(o_full),      DW'(n == int'(DP)));
    chk("empty",     DW'(o_empty),     DW'(n == 0));
    chk("alm_full",  DW'(o_alm_full),  DW'(n >= int'(DP - UT)));
    chk("alm_empty", DW'(o_alm_empty), DW'(n <= int'(LT)));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow",  DW'(o_overflow),  DW'(exp_ovf));
    chk("underflow", DW'(o_underflow), DW'(exp_unf));
`endif
  endtask

  // One clock: drive strobes, advance the model at the edge, check #1 later.
  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd);
    int n;
    bit rok;
    bit wok;
    i_wren   = wr;
    i_wrdata = d;
    i_rden   = rd;
    @(posedge clk);
    n   = q.size();
    rok = rd && (n > 0);
    wok = wr && ((n < int'(DP)) || rok);
    if (rd && !rok) exp_unf = 1'b1;
    if (wr && !wok) exp_ovf = 1'b1;
    if (rok) exp_rd = q.pop_front();
    if (wok) q.push_back(d);
    #1;
    check_all();
    i_wren = 1'b0;
    i_rden = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rddata"},    o_rddata,         '0);
    chk({tag, "_full"},      DW'(o_full),      '0);
    chk({tag, "_empty"},     DW'(o_empty),     DW'(1));
    chk({tag, "_alm_full"},  DW'(o_alm_full),  '0);
    chk({tag, "_alm_empty"}, DW'(o_alm_empty), DW'(1));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, "_overflow"},  DW'(o_overflow),  '0);
    chk({tag, "_underflow"}, DW'(o_underflow), '0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    rst      = 1'b1;
    i_wren   = 1'b0;
    i_rden   = 1'b0;
    i_wrdata = '0;
    exp_rd   = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    cycle(0, '0, 0);

    // Fill with 0..DP-1, then drop an extra write while full.
    for (int i = 0; i < int'(DP); i++) cycle(1, DW'(i), 0);
    cycle(1, DW'(32'hDEAD), 0);

    // Read+write at full: the new word surfaces after DP-1 further reads.
    cycle(1, DW'(32'hF0F0_0001), 1);
    chk("full_rw_word0", o_rddata, '0);
    while (q.size() > 0) cycle(0, '0, 1);
    chk("full_rw_last", o_rddata, DW'(32'hF0F0_0001));

    // Underflow: reads at empty must leave o_rddata alone.
    cycle(0, '0, 1);
    cycle(0, '0, 1);
    chk("unf_hold", o_rddata, DW'(32'hF0F0_0001));

    // Read+write at empty, then a run at count 1.
    cycle(1, rnd_word(), 1);
    for (int i = 0; i < 20; i++) cycle(1, rnd_word(), 1);
    cycle(0, '0, 1);

    // Alternating pairs wrap both pointers many times.
    for (int i = 0; i < 3000; i++) begin
      cycle(1, rnd_word(), 0);
      cycle(0, '0, 1);
    end

    // Biased random traffic towards full, then back towards empty.
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) < 9, rnd_word(), $urandom_range(0, 9) < 2);
    for (int i = 0; i < 2500; i++)
      cycle($urandom_range(0, 9) < 2, rnd_word(), $urandom_range(0, 9) < 9);

    // Reset in the middle of a cycle with count = 500.
    while (q.size() < 500) cycle(1, rnd_word(), 0);
    while (q.size() > 500) cycle(0, '0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    q.delete();
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    rst = 1'b0;
    w = DW'(128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
    cycle(1, w, 0);
    cycle(0, '0, 1);
    chk("post_rst_data", o_rddata, w);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
# sync_fifo_core

Synchronous single-clock FIFO that acts as the responder on the team's FIFO interface. It accepts write and read strobes from the bench driver or the upstream logic, and stores DATA_W-bit words in a DEPTH-entry circular buffer. It returns registered read data together with full, empty, almost-full and almost-empty status, which the output monitor samples.

## Interface
- DATA_W, 128: word width in bits.
- DEPTH, 1024: number of entries; must be a power of two and at least 4.
- UPP_TH, 4: almost-full margin, counted in entries below full.
- LOW_TH, 2: almost-empty level, in entries.
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous reset, active-high.
- i_wren  input  1  write strobe.
- i_wrdata  input  DATA_W  write data, sampled with i_wren.
- i_rden  input  1  read strobe.
- o_rddata  output  DATA_W  registered read data.
- o_full  output  1  count == DEPTH.
- o_empty  output  1  count == 0.
- o_alm_full  output  1  count >= DEPTH-UPP_TH.
- o_alm_empty  output  1  count <= LOW_TH.

## Operation
- State: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register of $clog2(DEPTH)+1 bits.
- Write accepted: wr_acc = i_wren & (!o_full | rd_acc).
  - On acceptance, mem[wr_ptr] <= i_wrdata and wr_ptr increments, wrapping naturally from DEPTH-1 to 0.
- Read accepted: rd_acc = i_rden & !o_empty.
  - On acceptance, o_rddata <= mem[rd_ptr] and rd_ptr increments with the same wrap.
- Count update: count += wr_acc - rd_acc.
- All flags are registered and derived from the next-count value, so they are exact in the same cycle as the count.
- Write while full with no read: dropped, with no pointer or memory change.
- Read while empty: ignored and o_rddata holds its value. This also applies when a write arrives in the same cycle, because there is no fall-through.
- Simultaneous write and read:
  - Empty: the write alone is accepted, so count becomes 1.
  - Full: both are accepted and count stays at DEPTH.
  - Otherwise: both are accepted and count is unchanged.
- o_rddata holds its last value whenever no read is accepted.
- Reset, including mid-operation: pointers and count go to 0.
  - o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
  - Memory contents are not cleared; the data is considered lost.

## Timing
- The write-to-read latency is 1 cycle. A word written at edge N is readable by an i_rden sampled at edge N+1, and appears on o_rddata after edge N+1.
- The read latency is 1 cycle. o_rddata is valid after the edge that accepted i_rden.
- Flags update on the same edge as the accepting strobe.
  - Example: with count=DEPTH-1, a write sets o_full after that edge.
- Inputs are sampled only at the rising clock edge. Bench drive skew is the clocking-block #1.
- Reset assertion takes effect asynchronously. Release is synchronous-safe, and the first strobe is honoured on the first edge after rst falls.

## Configuration
- FIFO_ERR_FLAGS_EN defined: adds two outputs, both 1 bit, reset to 0.
  - o_overflow: sticky; set when a write is dropped because the FIFO is full.
  - o_underflow: sticky; set when a read is ignored because the FIFO is empty.
  - Both are cleared only by rst.
- Undefined: these ports are absent and dropped or ignored accesses are silent.

## Structure
- Package fifo_pkg holds the following, shared with the interface and the bench:
  - the default parameter constants (DATA_W, DEPTH, UPP_TH, LOW_TH);
  - the ptr_t and cnt_t typedefs, parameterised through localparams;
  - a function computing the almost-flag thresholds.
- Sub-module fifo_ram is a simple dual-port RAM (DEPTH x DATA_W).
  - Write port: we, waddr, wdata.
  - Read port: re, raddr, registered rdata, which drives o_rddata directly.
- Pointer, count and flag logic lives in sync_fifo_core.

## Test plan
- Reset then idle: o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
- Fill and drain:
  - Write DEPTH words 0..1023. o_alm_full asserts after word 1020 (count 1020), and o_full after word 1024.
  - Read all words back: data returns 0..1023 in order, and o_empty asserts after the last read.
- Overflow at full: an extra write of 0xDEAD is dropped, the next read returns word 0, and o_overflow=1 when FIFO_ERR_FLAGS_EN is defined.
- Underflow at empty: i_rden while empty leaves o_rddata unchanged, and o_underflow=1 when the macro is defined.
- Simultaneous read and write:
  - At count=1: count stays at 1 and data is ordered.
  - At empty: count becomes 1.
  - At full: o_full stays 1 and the written word emerges after DEPTH-1 further reads.
- Wrap and reset mid-operation:
  - Perform 3000 alternating write/read pairs; no data mismatch is allowed across pointer wrap.
  - Assert rst with count=500: the flags return to their reset values immediately, and the next write/read returns the new data.
